stage_mem: RTL and testbench

- Memory-access stage of the RV32I multicycle core; sits directly downstream of the execute stage.
- Takes the ALU result as the byte address and rs2 data as store data.
- Runs one load or store per start pulse over a req/ready data-memory handshake: store byte-lane steering, load lane selection with sign/zero extension, alignment/illegal checks and a wait-state timeout.
- Reports completion with a one-cycle done pulse to the control FSM.

---
 rtl/stage_mem.sv | 163 ++++++++++++++++
 tb/tb_stage_mem.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/stage_mem.sv
// RV32I memory-access stage: one load/store per start pulse over a req/ready data-memory port.
// Latency: done at start+2 with zero wait states; backpressure is dmem_ready wait states, bounded by TIMEOUT.
module stage_mem #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, state_nxt;
    logic [2:0]    f3_q;
    logic [1:0]    lane_q;
    logic [CW-1:0] wait_cnt;

    logic          req_noop, req_illegal, req_misal, req_ok;
    logic          accept, timeout_hit;
    logic [3:0]    be_nxt;
    logic [31:0]   wdata_nxt;
    logic [31:0]   load_ext;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    // Request classification works on the live inputs so it can be registered on the accepting edge.
    always_comb begin
        req_noop    = !mem_read && !mem_write;
        req_illegal = (mem_read && mem_write)
                   || (mem_read && !mem_write && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
                   || (mem_write && !mem_read && !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010));
        req_misal   = !req_noop && !req_illegal
                   && ((funct3[1:0] == 2'b01 && alu_result[0])
                    || (funct3[1:0] == 2'b10 && alu_result[1:0] != 2'b00));
        req_ok      = !req_noop && !req_illegal && !req_misal;
    end

    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = store_data;
        if (mem_write) begin
            case (funct3[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << alu_result[1:0];
                    wdata_nxt = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_nxt    = alu_result[1] ? 4'b1100 : 4'b0011;
                    wdata_nxt = {2{store_data[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = store_data;
                end
            endcase
        end
    end

    always_comb begin
        rd_byte  = dmem_rdata[8*lane_q +: 8];
        rd_half  = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_ext = dmem_rdata;
        case (f3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Ready has priority over the timeout when both land in the same cycle.
    assign timeout_hit = (TIMEOUT != 0) && !dmem_ready && (wait_cnt + 1'b1 == TO_LIM);
    assign accept      = (state == IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        dmem_req  = (state == ACCESS);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = req_ok ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                if (dmem_ready || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f3_q        <= 3'd0;
            lane_q      <= 2'd0;
            wait_cnt    <= '0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_wdata  <= 32'd0;
            dmem_be     <= 4'd0;
            load_data   <= 32'd0;
            fault       <= 1'b0;
            fault_cause <= 2'd0;
        end else if (accept) begin
            fault       <= req_illegal || req_misal;
            fault_cause <= req_illegal ? 2'b11 : (req_misal ? 2'b01 : 2'b00);
            if (req_ok) begin
                f3_q       <= funct3;
                lane_q     <= alu_result[1:0];
                wait_cnt   <= '0;
                dmem_we    <= mem_write;
                dmem_addr  <= {alu_result[31:2], 2'b00};
                dmem_wdata <= wdata_nxt;
                dmem_be    <= be_nxt;
            end
        end else if (state == ACCESS) begin
            if (dmem_ready) begin
                if (!dmem_we) begin
                    load_data <= load_ext;
                end
            end else if (timeout_hit) begin
                fault       <= 1'b1;
                fault_cause <= 2'b10;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem with TIMEOUT=4; memory side is driven by hand per access.
module tb_stage_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        busy, done;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int          n_checks = 0;
    int          n_errors = 0;
    int          lat, req_cycles;
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;

    always #5 clk = ~clk;

    stage_mem #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .alu_result(alu_result), .store_data(store_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .busy(busy), .done(done), .load_data(load_data),
        .fault(fault), .fault_cause(fault_cause)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // waits < 0 means the memory never answers. lat counts negedges after the start edge until done.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input logic [31:0] rdata, input int waits);
        int w;
        @(negedge clk);
        start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3;
        alu_result = addr; store_data = sd; dmem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        lat = 1; req_cycles = 0; w = 0;
        while (!done && lat < 40) begin
            if (dmem_req) begin
                req_cycles++;
                obs_addr = dmem_addr; obs_wdata = dmem_wdata; obs_be = dmem_be; obs_we = dmem_we;
                dmem_ready = (waits >= 0) && (w == waits);
                dmem_rdata = rdata;
                w++;
            end else begin
                dmem_ready = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        dmem_ready = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
        check("req_low_at_done", {31'd0, dmem_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        alu_result = 32'd0; store_data = 32'd0; dmem_ready = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {20'd0, dmem_req, dmem_we, busy, done, fault, fault_cause, dmem_be, 1'b0}, 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_load", load_data, 32'd0);
        rst = 1'b0;

        // SW 0x100
        run(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        check("sw_lat", lat, 2);
        check("sw_addr", obs_addr, 32'h100);
        check("sw_be", {28'd0, obs_be}, 32'hF);
        check("sw_wdata", obs_wdata, 32'hDEADBEEF);
        check("sw_we", {31'd0, obs_we}, 1);
        check("sw_fault", {29'd0, fault, fault_cause}, 0);

        // SB 0x203
        run(1'b0, 1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0);
        check("sb_addr", obs_addr, 32'h200);
        check("sb_be", {28'd0, obs_be}, 32'h8);
        check("sb_wdata", obs_wdata, 32'hA5A5A5A5);

        // SH 0x102
        run(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 0);
        check("sh_be", {28'd0, obs_be}, 32'hC);
        check("sh_wdata", obs_wdata, 32'hABCDABCD);

        // LB 0x102 with two wait states
        run(1'b1, 1'b0, 3'b000, 32'h102, 32'h0, 32'h12803456, 2);
        check("lb_lat", lat, 4);
        check("lb_data", load_data, 32'hFFFFFF80);
        check("lb_we_be", {27'd0, obs_we, obs_be}, 32'h0F);
        check("lb_addr", obs_addr, 32'h100);

        run(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 32'h12803456, 0);
        check("lbu_data", load_data, 32'h00000080);
        run(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h12803456, 0);
        check("lh_data", load_data, 32'h00001280);
        run(1'b1, 1'b0, 3'b001, 32'h100, 32'h0, 32'h12808456, 1);
        check("lh_neg_data", load_data, 32'hFFFF8456);
        run(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h12808456, 0);
        check("lhu_data", load_data, 32'h00008456);
        run(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h89ABCDEF, 0);
        check("lw_data", load_data, 32'h89ABCDEF);

        // Misaligned LW
        run(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        check("mis_lat", lat, 1);
        check("mis_noreq", req_cycles, 0);
        check("mis_fault", {29'd0, fault, fault_cause}, 32'b101);
        check("mis_load_kept", load_data, 32'h89ABCDEF);

        // Illegal: read+write, load funct3 011, store funct3 100
        run(1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 0);
        check("ill_rw", {29'd0, fault, fault_cause}, 32'b111);
        check("ill_rw_lat", lat, 1);
        run(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
        check("ill_ld", {29'd0, fault, fault_cause}, 32'b111);
        run(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0);
        check("ill_st", {29'd0, fault, fault_cause}, 32'b111);

        // No-op clears the fault
        run(1'b0, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0);
        check("noop_lat", lat, 1);
        check("noop_noreq", req_cycles, 0);
        check("noop_fault", {29'd0, fault, fault_cause}, 0);

        // Timeout after four unanswered cycles
        run(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h55555555, -1);
        check("to_req_cycles", req_cycles, 4);
        check("to_lat", lat, 5);
        check("to_fault", {29'd0, fault, fault_cause}, 32'b110);
        check("to_load_kept", load_data, 32'h89ABCDEF);

        // Ready in the last allowed cycle still succeeds
        run(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADCAFE, 3);
        check("edge_lat", lat, 5);
        check("edge_fault", {29'd0, fault, fault_cause}, 0);
        check("edge_data", load_data, 32'h0BADCAFE);

        // Start while busy is ignored
        @(negedge clk);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h100;
        @(negedge clk);
        check("busy_req", {31'd0, dmem_req}, 1);
        mem_read = 1'b0; mem_write = 1'b1; alu_result = 32'h300; store_data = 32'h11111111;
        @(negedge clk);
        start = 1'b0;
        check("busy_addr_held", dmem_addr, 32'h100);
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        dmem_ready = 1'b0;
        check("busy_done", {31'd0, done}, 1);
        check("busy_load", load_data, 32'hCAFEF00D);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("busy_no_second", {30'd0, dmem_req, busy}, 0);
        end

        // Asynchronous reset during ACCESS
        @(negedge clk);
        start = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h108;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_req", {31'd0, dmem_req}, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_ctl", {29'd0, dmem_req, busy, done}, 0);
        check("arst_load", load_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 32'h600DF00D, 1);
        check("post_rst_lat", lat, 3);
        check("post_rst_data", load_data, 32'h600DF00D);
        check("post_rst_addr", obs_addr, 32'h10C);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
